// File: rtl/vec_div_pkg.sv
// vec_div_pkg: shared state encoding, width defaults and fill value for the vector-divide sequencer.
package vec_div_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, OUT} state_e;
  localparam int DATA_W_DEF = 16;
  localparam int DOUT_W_DEF = 32;
  localparam logic [DOUT_W_DEF-1:0] ZERO_FILL = '0;
endpackage

// File: rtl/vec_buf.sv
// vec_buf: single-write single-read register array with combinational read, contents not reset.
module vec_buf #(
  parameter int DEPTH = 8,
  parameter int W = 16,
  parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/vec_div_sequencer.sv
// vec_div_sequencer: buffers a vector, issues element/norm pairs to the divider one per cycle,
// collects quotients in issue order and streams them out with ready/valid.
module vec_div_sequencer
  import vec_div_pkg::*;
#(
  parameter int N_MAX = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] norm_tdata,
  input  logic              norm_tvalid,
  input  logic [DATA_W-1:0] s_vec_tdata,
  input  logic              s_vec_tvalid,
  input  logic              s_vec_tlast,
  output logic              s_vec_tready,
  output logic [DATA_W-1:0] m_axis_dividend_tdata,
  output logic [DATA_W-1:0] m_axis_divisor_tdata,
  output logic              m_axis_dividend_tvalid,
  output logic              m_axis_divisor_tvalid,
  input  logic [DOUT_W-1:0] s_axis_dout_tdata,
  input  logic              s_axis_dout_tvalid,
  output logic [DOUT_W-1:0] m_res_tdata,
  output logic              m_res_tvalid,
  output logic              m_res_tlast,
  input  logic              m_res_tready,
  output logic              busy,
  output logic              err_div0,
  output logic              err_timeout
);
  localparam int CW = $clog2(N_MAX + 1);
  localparam int AW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_MAX - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_e            state_q;
  logic [DATA_W-1:0] norm_q, elem_rd;
  logic [DOUT_W-1:0] res_rd;
  logic [CW-1:0]     len_q, iss_q, rcv_q, oidx_q;
  logic [TW-1:0]     timer_q;
  logic              err_div0_q, err_to_q;
  logic              load_we, cap_we, cap_done, out_last;

  assign load_we  = (state_q == LOAD) && s_vec_tvalid;
  assign cap_we   = (state_q == ISSUE || state_q == WAIT) && s_axis_dout_tvalid && rcv_q != len_q;
  assign cap_done = (rcv_q == len_q) || (cap_we && rcv_q + CW'(1) == len_q);
  assign out_last = oidx_q == len_q - CW'(1);

  vec_buf #(.DEPTH(N_MAX), .W(DATA_W), .AW(AW)) u_elem (
    .clk     (aclk),
    .we_i    (load_we),
    .waddr_i (len_q[AW-1:0]),
    .wdata_i (s_vec_tdata),
    .raddr_i (iss_q[AW-1:0]),
    .rdata_o (elem_rd)
  );

  vec_buf #(.DEPTH(N_MAX), .W(DOUT_W), .AW(AW)) u_res (
    .clk     (aclk),
    .we_i    (cap_we),
    .waddr_i (rcv_q[AW-1:0]),
    .wdata_i (s_axis_dout_tdata),
    .raddr_i (oidx_q[AW-1:0]),
    .rdata_o (res_rd)
  );

  assign s_vec_tready           = state_q == LOAD;
  assign m_axis_dividend_tvalid = state_q == ISSUE;
  assign m_axis_divisor_tvalid  = state_q == ISSUE;
  assign m_axis_dividend_tdata  = (state_q == ISSUE) ? elem_rd : '0;
  assign m_axis_divisor_tdata   = (state_q == ISSUE) ? norm_q : '0;
  assign m_res_tvalid           = state_q == OUT;
  // Slots never captured (divide-by-zero or timeout) read as the zero fill.
  assign m_res_tdata            = (state_q == OUT && oidx_q < rcv_q) ? res_rd : DOUT_W'(ZERO_FILL);
  assign m_res_tlast            = (state_q == OUT) && out_last;
  assign busy                   = state_q != IDLE;
  assign err_div0               = err_div0_q;
  assign err_timeout            = err_to_q;

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q    <= IDLE;
      norm_q     <= '0;
      len_q      <= '0;
      iss_q      <= '0;
      rcv_q      <= '0;
      oidx_q     <= '0;
      timer_q    <= '0;
      err_div0_q <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      if (cap_we) rcv_q <= rcv_q + CW'(1);
      case (state_q)
        IDLE:
          if (norm_tvalid) begin
            norm_q     <= norm_tdata;
            err_div0_q <= 1'b0;
            err_to_q   <= 1'b0;
            len_q      <= '0;
            iss_q      <= '0;
            rcv_q      <= '0;
            oidx_q     <= '0;
            timer_q    <= '0;
            state_q    <= LOAD;
          end
        LOAD:
          if (s_vec_tvalid) begin
            len_q <= len_q + CW'(1);
            if (s_vec_tlast || len_q == LAST) begin
              err_div0_q <= norm_q == '0;
              state_q    <= (norm_q == '0) ? OUT : ISSUE;
            end
          end
        ISSUE: begin
          iss_q <= iss_q + CW'(1);
          if (iss_q == len_q - CW'(1)) begin
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (cap_done) state_q <= OUT;
          else if (timer_q == TLIM) begin
            err_to_q <= 1'b1;
            state_q  <= OUT;
          end
        end
        OUT:
          if (m_res_tready) begin
            oidx_q <= oidx_q + CW'(1);
            if (out_last) state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vec_div_sequencer.sv
// tb_vec_div_sequencer: randomized bench with a latency/dropping divider stub and a per-vector expected-result model.
module tb_vec_div_sequencer;
  localparam int N_MAX = 8, TIMEOUT = 64;
  logic        aclk = 0, areset = 1;
  logic [15:0] norm_tdata = '0, s_vec_tdata = '0;
  logic        norm_tvalid = 0, s_vec_tvalid = 0, s_vec_tlast = 0, s_vec_tready;
  logic [15:0] dvd, dvs;
  logic        dvd_v, dvs_v;
  logic [31:0] dout = '0, res;
  logic        dout_v = 0, res_v, res_last, res_rdy = 0;
  logic        busy, err_div0, err_timeout;
  int          checks = 0, errors = 0, cyc = 0;
  int          lat = 1, deliver = N_MAX, n_issued = 0, last_issue = 0, last_dout = 0, pair_bad = 0;
  int          due_q[$];
  logic [31:0] val_q[$];
  logic [15:0] iss_dvd[$], iss_dvs[$];
  logic [15:0] vec [N_MAX];
  bit   [3:0]  pat = 4'b1001;

  vec_div_sequencer dut (
    .aclk(aclk), .areset(areset),
    .norm_tdata(norm_tdata), .norm_tvalid(norm_tvalid),
    .s_vec_tdata(s_vec_tdata), .s_vec_tvalid(s_vec_tvalid), .s_vec_tlast(s_vec_tlast), .s_vec_tready(s_vec_tready),
    .m_axis_dividend_tdata(dvd), .m_axis_divisor_tdata(dvs),
    .m_axis_dividend_tvalid(dvd_v), .m_axis_divisor_tvalid(dvs_v),
    .s_axis_dout_tdata(dout), .s_axis_dout_tvalid(dout_v),
    .m_res_tdata(res), .m_res_tvalid(res_v), .m_res_tlast(res_last), .m_res_tready(res_rdy),
    .busy(busy), .err_div0(err_div0), .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic logic [31:0] f(input logic [15:0] x, input logic [15:0] d);
    int q, r;
    q = int'($signed(x)) / int'($signed(d));
    r = int'($signed(x)) % int'($signed(d));
    return {q[15:0], r[15:0]};
  endfunction

  function automatic logic [15:0] rnz();
    logic [15:0] v;
    v = 16'($urandom);
    return (v == '0) ? 16'h0001 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Divider stub: fixed latency, returns only the first `deliver` results of a vector.
  always @(negedge aclk) begin
    if (areset) begin
      due_q.delete();
      val_q.delete();
      dout_v = 0;
    end else begin
      if (dvd_v !== dvs_v) pair_bad++;
      if (dvd_v) begin
        iss_dvd.push_back(dvd);
        iss_dvs.push_back(dvs);
        if (n_issued < deliver) begin
          due_q.push_back(cyc + lat);
          val_q.push_back(f(dvd, dvs));
        end
        n_issued++;
        last_issue = cyc;
      end
      dout_v = 0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        dout_v = 1;
        dout = val_q.pop_front();
        due_q.delete(0);
        last_dout = cyc;
      end
    end
  end

  task automatic run_vec(input logic [15:0] norm, input int n, input bit tl, input int l, input int dlv, input bit stall);
    logic [31:0] exp_r [N_MAX];
    logic [31:0] held;
    bit exp_to, was_stall;
    int got, t, k, fe, first_v;
    exp_to = 0;
    held = '0;
    // A result counts only if delivered and back within TIMEOUT cycles of the last issue.
    for (int i = 0; i < n; i++) begin
      if (norm == 0) exp_r[i] = '0;
      else if (i < dlv && l - (n - 1 - i) <= TIMEOUT) exp_r[i] = f(vec[i], norm);
      else begin
        exp_r[i] = '0;
        exp_to = 1;
      end
    end
    lat = l; deliver = dlv; n_issued = 0;
    iss_dvd.delete(); iss_dvs.delete();
    norm_tdata = norm; norm_tvalid = 1;
    @(negedge aclk);
    norm_tvalid = 0;
    chk("busy_on", busy, 1);
    chk("err_clr", {err_div0, err_timeout}, 0);
    for (int i = 0; i < n; i++) begin
      chk("vec_tready", s_vec_tready, 1);
      s_vec_tvalid = 1; s_vec_tdata = vec[i]; s_vec_tlast = tl && i == n - 1;
      @(negedge aclk);
    end
    s_vec_tvalid = 0; s_vec_tlast = 0;
    chk("tready_drop", s_vec_tready, 0);
    chk("first_issue", dvd_v, norm != 0);
    got = 0; t = 0; k = 0; fe = -1; first_v = -1; was_stall = 0;
    while (got < n && t < 400) begin
      if (err_timeout && fe < 0) fe = cyc;
      if (was_stall) begin
        chk("stall_v", res_v, 1);
        chk("stall_hold", res, held);
      end
      was_stall = 0; res_rdy = 0;
      if (res_v) begin
        if (first_v < 0) first_v = cyc;
        res_rdy = stall ? pat[k % 4] : 1'b1;
        k++;
        if (res_rdy) begin
          chk($sformatf("res%0d", got), res, exp_r[got]);
          chk("res_last", res_last, got == n - 1);
          got++;
        end else begin
          held = res;
          was_stall = 1;
        end
      end
      @(negedge aclk);
      t++;
    end
    res_rdy = 0;
    chk("all_out", got, n);
    chk("busy_off", busy, 0);
    chk("res_v_off", res_v, 0);
    chk("n_issued", n_issued, norm == 0 ? 0 : n);
    chk("tvalid_pair", pair_bad, 0);
    for (int i = 0; i < iss_dvd.size() && i < n; i++) begin
      chk("dividend", iss_dvd[i], vec[i]);
      chk("divisor", iss_dvs[i], norm);
    end
    chk("err_div0", err_div0, norm == 0);
    chk("err_timeout", err_timeout, exp_to);
    // Edges from the one carrying the last issue to the one raising the flag.
    if (exp_to && norm != 0) chk("to_edges", fe - last_issue - 1, TIMEOUT);
    if (!exp_to && norm != 0) chk("out_lat", first_v - last_dout, 1);
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_tready", s_vec_tready, 0);
    chk("rst_issue_v", {dvd_v, dvs_v}, 0);
    chk("rst_issue_d", {dvd, dvs}, 0);
    chk("rst_res_v", res_v, 0);
    chk("rst_res_d", res, 0);
    chk("rst_err", {err_div0, err_timeout}, 0);
    areset = 0;
    vec[0] = 16'h0004; vec[1] = 16'hFFF8; vec[2] = 16'h0006;
    run_vec(16'h0002, 3, 1, 20, N_MAX, 0);
    for (int i = 0; i < N_MAX; i++) vec[i] = 16'($urandom);
    run_vec(rnz(), 8, 0, 7, N_MAX, 0);
    run_vec(16'h0000, 2, 1, 5, N_MAX, 0);
    for (int i = 0; i < N_MAX; i++) vec[i] = 16'($urandom);
    run_vec(rnz(), 3, 1, 4, 2, 0);
    run_vec(rnz(), 4, 1, 3, N_MAX, 1);
    run_vec(rnz(), 3, 1, TIMEOUT, N_MAX, 0);
    run_vec(rnz(), 3, 1, TIMEOUT + 1, N_MAX, 0);
    // Reset in the middle of issuing, then a clean vector.
    lat = 20; deliver = N_MAX; n_issued = 0;
    norm_tdata = 16'h0003; norm_tvalid = 1;
    @(negedge aclk);
    norm_tvalid = 0;
    for (int i = 0; i < 5; i++) begin
      s_vec_tvalid = 1; s_vec_tdata = vec[i]; s_vec_tlast = i == 4;
      @(negedge aclk);
    end
    s_vec_tvalid = 0; s_vec_tlast = 0;
    @(negedge aclk);
    chk("mid_issue", dvd_v, 1);
    areset = 1;
    #1;
    chk("arst_issue_v", {dvd_v, dvs_v}, 0);
    chk("arst_issue_d", {dvd, dvs}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_misc", {s_vec_tready, res_v, res_last, err_div0, err_timeout}, 0);
    repeat (2) @(negedge aclk);
    areset = 0;
    run_vec(16'h0005, 4, 1, 6, N_MAX, 0);
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, N_MAX);
      for (int i = 0; i < N_MAX; i++) vec[i] = 16'($urandom);
      run_vec(rnz(), n, n < N_MAX ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(1, 30), N_MAX, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
